// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared encodings for the Wishbone arbiters
package wb_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_e;

  localparam int WDOG_W = 16;

endpackage

// File: rtl/wb_rr_pick.sv
// rtl/wb_rr_pick.sv - round-robin picker: rotate, take lowest request, rotate back
module wb_rr_pick #(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] back;
  logic [N-1:0]   rot;
  logic [N-1:0]   pri;
  int unsigned    shift;

  always_comb begin
    shift = (int'(last_i) + 1) % N;
    // bit 0 of the rotated vector is the master right after the last winner
    dbl   = {req_i, req_i} >> shift;
    rot   = dbl[N-1:0];
    pri   = rot & (~rot + N'(1));
    back  = {pri, pri} << shift;
    gnt_o = back[2*N-1:N];
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - round-robin Wishbone B3 arbiter with per-transfer watchdog
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int num_masters = 2,
  parameter int dw          = 32,
  parameter int aw          = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic [num_masters*aw-1:0]   wbm_adr_i,
  input  logic [num_masters*dw-1:0]   wbm_dat_i,
  input  logic [num_masters*dw/8-1:0] wbm_sel_i,
  input  logic [num_masters-1:0]      wbm_we_i,
  input  logic [num_masters-1:0]      wbm_cyc_i,
  input  logic [num_masters-1:0]      wbm_stb_i,
  input  logic [num_masters*3-1:0]    wbm_cti_i,
  input  logic [num_masters*2-1:0]    wbm_bte_i,
  output logic [num_masters*dw-1:0]   wbm_rdt_o,
  output logic [num_masters-1:0]      wbm_ack_o,
  output logic [num_masters-1:0]      wbm_err_o,
  output logic [num_masters-1:0]      wbm_rty_o,
  output logic [aw-1:0]               wbs_adr_o,
  output logic [dw-1:0]               wbs_dat_o,
  output logic [dw/8-1:0]             wbs_sel_o,
  output logic                        wbs_we_o,
  output logic                        wbs_cyc_o,
  output logic                        wbs_stb_o,
  output logic [2:0]                  wbs_cti_o,
  output logic [1:0]                  wbs_bte_o,
  input  logic [dw-1:0]               wbs_rdt_i,
  input  logic                        wbs_ack_i,
  input  logic                        wbs_err_i,
  input  logic                        wbs_rty_i,
  output logic [num_masters-1:0]      grant_o
);

  localparam int IW = $clog2(num_masters);

  arb_state_e               state_q, state_d;
  logic [num_masters-1:0]   grant_q, grant_d;
  logic [IW-1:0]            last_q, last_d;
  logic [WDOG_W-1:0]        wdog_q, wdog_d;

  logic [num_masters-1:0]   pick_gnt;
  logic [IW-1:0]            pick_idx;
  logic [IW-1:0]            owner_idx;
  logic                     owner_cyc;
  logic                     owner_stb;
  logic                     slv_term;
  logic                     wdog_fire;

  wb_rr_pick #(.N(num_masters)) u_pick (
    .req_i  (wbm_cyc_i),
    .last_i (last_q),
    .gnt_o  (pick_gnt)
  );

  // With no owner the index falls back to 0 so the slave bus never carries X.
  always_comb begin
    owner_idx = '0;
    pick_idx  = '0;
    for (int i = 0; i < num_masters; i++) begin
      if (grant_q[i])  owner_idx = IW'(i);
      if (pick_gnt[i]) pick_idx  = IW'(i);
    end
  end

  assign owner_cyc = |(wbm_cyc_i & grant_q);
  assign owner_stb = |(wbm_stb_i & grant_q);
  assign slv_term  = wbs_ack_i | wbs_err_i | wbs_rty_i;
  assign wdog_fire = (state_q == ARB_OWNED) && owner_stb && (wdog_q == WDOG_W'(TIMEOUT));

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wdog_d  = wdog_q;
    case (state_q)
      ARB_IDLE: begin
        wdog_d = '0;
        if (|wbm_cyc_i) begin
          state_d = ARB_OWNED;
          grant_d = pick_gnt;
          last_d  = pick_idx;
        end
      end
      ARB_OWNED: begin
        if (!owner_cyc) begin
          state_d = ARB_IDLE;
          grant_d = '0;
          wdog_d  = '0;
        end else if (wdog_fire || slv_term) begin
          wdog_d = '0;
        end else if (owner_stb) begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
        wdog_d  = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= IW'(num_masters - 1);
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end

  assign wbs_adr_o = wbm_adr_i[owner_idx*aw +: aw];
  assign wbs_dat_o = wbm_dat_i[owner_idx*dw +: dw];
  assign wbs_sel_o = wbm_sel_i[owner_idx*(dw/8) +: dw/8];
  assign wbs_we_o  = wbm_we_i[owner_idx];
  assign wbs_cti_o = wbm_cti_i[owner_idx*3 +: 3];
  assign wbs_bte_o = wbm_bte_i[owner_idx*2 +: 2];
  assign wbs_cyc_o = owner_cyc;
  // The firing cycle withdraws the strobe so a late slave ack cannot complete it.
  assign wbs_stb_o = owner_stb & ~wdog_fire;

  assign wbm_rdt_o = {num_masters{wbs_rdt_i}};
  assign wbm_ack_o = grant_q & {num_masters{wbs_ack_i & ~wdog_fire}};
  assign wbm_err_o = grant_q & {num_masters{wbs_err_i | wdog_fire}};
  assign wbm_rty_o = grant_q & {num_masters{wbs_rty_i & ~wdog_fire}};
  assign grant_o   = grant_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb/tb_wb_rr_arbiter.sv - self-checking bench for wb_rr_arbiter
module tb_wb_rr_arbiter;

  localparam int NM = 2;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam logic [31:0] A0 = 32'h1000_0000;
  localparam logic [31:0] A1 = 32'h2000_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic [NM*AW-1:0]  wbm_adr_i;
  logic [NM*DW-1:0]  wbm_dat_i;
  logic [NM*DW/8-1:0] wbm_sel_i;
  logic [NM-1:0]     wbm_we_i, wbm_cyc_i, wbm_stb_i;
  logic [NM*3-1:0]   wbm_cti_i;
  logic [NM*2-1:0]   wbm_bte_i;
  logic [NM*DW-1:0]  wbm_rdt_o;
  logic [NM-1:0]     wbm_ack_o, wbm_err_o, wbm_rty_o, grant_o;
  logic [AW-1:0]     wbs_adr_o;
  logic [DW-1:0]     wbs_dat_o, wbs_rdt_i;
  logic [DW/8-1:0]   wbs_sel_o;
  logic              wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [2:0]        wbs_cti_o;
  logic [1:0]        wbs_bte_o;
  logic              wbs_ack_i, wbs_err_i, wbs_rty_i;

  int checks = 0;
  int failures = 0;

  wb_rr_arbiter #(.num_masters(NM), .dw(DW), .aw(AW), .TIMEOUT(8)) dut (
    .wb_clk_i (clk),       .wb_rst_i (rst),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
    .wbm_we_i (wbm_we_i),  .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i),
    .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i), .wbm_rdt_o(wbm_rdt_o),
    .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_we_o (wbs_we_o),  .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
    .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o), .wbs_rdt_i(wbs_rdt_i),
    .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i),
    .grant_o  (grant_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, actual=running required=done");
    $fatal(1);
  end

  typedef struct {
    logic [1:0]  cyc;
    logic [1:0]  stb;
    logic        ack;
    logic        err;
    logic        rty;
    logic [1:0]  e_grant;
    logic        e_cyc;
    logic        e_stb;
    logic [1:0]  e_ack;
    logic [1:0]  e_err;
    logic [1:0]  e_rty;
    logic [31:0] e_adr;
  } vec_t;

  vec_t vt[20];
  vec_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input logic [1:0] cyc, input logic [1:0] stb);
    wbm_cyc_i = cyc;
    wbm_stb_i = stb;
  endtask

  initial begin
    vec_t e;
    vt[0]  = '{2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, A0};
    vt[1]  = '{2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, A1};
    vt[2]  = '{2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 2'b10, 2'b00, 2'b00, A1};
    vt[3]  = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, A1};
    vt[4]  = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, A0};
    vt[5]  = '{2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, A0};
    vt[6]  = '{2'b11, 2'b11, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 2'b01, 2'b00, 2'b00, A0};
    vt[7]  = '{2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, A0};
    vt[8]  = '{2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, A0};
    vt[9]  = '{2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 2'b10, 2'b00, 2'b00, A1};
    vt[10] = '{2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, A1};
    vt[11] = '{2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, A0};
    vt[12] = '{2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, A0};
    vt[13] = '{2'b11, 2'b11, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00, 2'b01, 2'b00, A0};
    vt[14] = '{2'b11, 2'b11, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 2'b00, 2'b00, 2'b01, A0};
    vt[15] = '{2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, A0};
    vt[16] = '{2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, A0};
    vt[17] = '{2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 2'b10, 2'b00, 2'b00, A1};
    vt[18] = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, A1};
    vt[19] = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, A0};

    rst       = 1'b1;
    wbm_adr_i = {A1, A0};
    wbm_dat_i = {32'hBBBB_0001, 32'hAAAA_0000};
    wbm_sel_i = 8'hF3;
    wbm_we_i  = 2'b01;
    wbm_cyc_i = 2'b00;
    wbm_stb_i = 2'b00;
    wbm_cti_i = 6'b000_000;
    wbm_bte_i = 4'b00_00;
    wbs_rdt_i = 32'hDEAD_BEEF;
    wbs_ack_i = 1'b0;
    wbs_err_i = 1'b0;
    wbs_rty_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("reset_grant", grant_o, 2'b00);
    chk("reset_cyc", wbs_cyc_o, 1'b0);
    chk("reset_stb", wbs_stb_o, 1'b0);
    chk("reset_term", {wbm_ack_o, wbm_err_o, wbm_rty_o}, 6'b0);
    chk("reset_adr", wbs_adr_o, A0);

    // Sequential vectors: single read by master 1, then alternating rounds.
    for (int i = 0; i < 20; i++) begin
      tick();
      set_m(vt[i].cyc, vt[i].stb);
      wbs_ack_i = vt[i].ack;
      wbs_err_i = vt[i].err;
      wbs_rty_i = vt[i].rty;
      sb.push_back(vt[i]);
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("v%0d_grant", i), grant_o, e.e_grant);
      chk($sformatf("v%0d_cyc", i), wbs_cyc_o, e.e_cyc);
      chk($sformatf("v%0d_stb", i), wbs_stb_o, e.e_stb);
      chk($sformatf("v%0d_ack", i), wbm_ack_o, e.e_ack);
      chk($sformatf("v%0d_err", i), wbm_err_o, e.e_err);
      chk($sformatf("v%0d_rty", i), wbm_rty_o, e.e_rty);
      chk($sformatf("v%0d_adr", i), wbs_adr_o, e.e_adr);
      chk($sformatf("v%0d_rdt", i), wbm_rdt_o, {2{32'hDEAD_BEEF}});
    end
    wbs_ack_i = 1'b0;

    // Master 0 incrementing burst while master 1 waits.
    tick();
    set_m(2'b11, 2'b11);
    wbm_cti_i = 6'b000_010;
    @(negedge clk);
    chk("burst_pre_grant", grant_o, 2'b00);
    for (int b = 0; b < 4; b++) begin
      tick();
      wbs_ack_i = 1'b1;
      wbm_cti_i = (b == 3) ? 6'b000_111 : 6'b000_010;
      @(negedge clk);
      chk($sformatf("burst%0d_grant", b), grant_o, 2'b01);
      chk($sformatf("burst%0d_cti", b), wbs_cti_o, (b == 3) ? 3'b111 : 3'b010);
      chk($sformatf("burst%0d_ack", b), wbm_ack_o, 2'b01);
      chk($sformatf("burst%0d_we", b), wbs_we_o, 1'b1);
    end
    tick();
    wbs_ack_i = 1'b0;
    set_m(2'b10, 2'b10);
    wbm_cti_i = 6'b000_000;
    @(negedge clk);
    chk("burst_rel_grant", grant_o, 2'b01);
    chk("burst_rel_cyc", wbs_cyc_o, 1'b0);
    tick();
    @(negedge clk);
    chk("burst_gap_grant", grant_o, 2'b00);
    tick();
    @(negedge clk);
    chk("burst_next_grant", grant_o, 2'b10);
    chk("burst_next_adr", wbs_adr_o, A1);
    tick();
    set_m(2'b00, 2'b00);
    tick();
    @(negedge clk);
    chk("burst_end_grant", grant_o, 2'b00);

    // Watchdog: two timeouts, the second with a coincident slave ack.
    tick();
    set_m(2'b01, 2'b01);
    @(negedge clk);
    chk("wd_pre_grant", grant_o, 2'b00);
    for (int r = 0; r < 2; r++) begin
      for (int k = 1; k <= 9; k++) begin
        tick();
        wbs_ack_i = (r == 1 && k == 9);
        @(negedge clk);
        chk($sformatf("wd%0d_%0d_stb", r, k), wbs_stb_o, (k != 9));
        chk($sformatf("wd%0d_%0d_err", r, k), wbm_err_o, (k == 9) ? 2'b01 : 2'b00);
        chk($sformatf("wd%0d_%0d_ack", r, k), wbm_ack_o, 2'b00);
      end
    end
    tick();
    wbs_ack_i = 1'b0;
    set_m(2'b00, 2'b00);
    tick();
    @(negedge clk);
    chk("wd_release_grant", grant_o, 2'b00);

    // Async reset in the middle of a master 0 burst.
    tick();
    set_m(2'b01, 2'b01);
    wbm_cti_i = 6'b000_010;
    tick();
    wbs_ack_i = 1'b1;
    @(negedge clk);
    chk("rst_pre_grant", grant_o, 2'b01);
    chk("rst_pre_ack", wbm_ack_o, 2'b01);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_cyc", wbs_cyc_o, 1'b0);
    chk("rst_async_stb", wbs_stb_o, 1'b0);
    chk("rst_async_grant", grant_o, 2'b00);
    chk("rst_async_term", {wbm_ack_o, wbm_err_o, wbm_rty_o}, 6'b0);
    tick();
    rst = 1'b0;
    wbs_ack_i = 1'b0;
    set_m(2'b11, 2'b11);
    @(negedge clk);
    chk("rst_post_idle", grant_o, 2'b00);
    tick();
    @(negedge clk);
    chk("rst_post_grant", grant_o, 2'b01);
    chk("rst_post_adr", wbs_adr_o, A0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
